// File: rtl/wps_recv.sv
// Video capture front end: drops the offset lines, trims each line to LINE_PIXELS
// and streams pixels into a pingpong buffer for a programmed number of frames.
module wps_recv #(
  parameter int unsigned LINE_PIXELS = 80,
  parameter int unsigned FRAME_LINES = 1081,
  parameter int unsigned SKIP_LINES  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] to_recv_frame_num_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        de_in,
  input  logic [23:0] pix_data_in,
  input  logic        pingpong_ready_in,
  output logic        pp_wr_en,
  output logic [23:0] pp_wr_data,
  output logic        frame_done,
  output logic        busy,
  output logic        overflow_err,
  output logic        short_frame_err,
  output logic [31:0] frame_cnt_out
);

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned LINE_W = 11;
  localparam int unsigned PCNT_W = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VSYNC,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic               h_sync_r, v_sync_r, de_r;
  logic               h_sync_q, v_sync_q, de_q;
  logic [PIX_W-1:0]   pix_data_r;
  logic [CNT_W-1:0]   target, target_d;
  logic [CNT_W-1:0]   frame_cnt_d, frame_cnt_inc;
  logic [LINE_W-1:0]  line_cnt, line_cnt_d, line_cur;
  logic [PCNT_W-1:0]  pix_cnt, pix_cnt_d, pix_cnt_inc;
  logic               wr_en_d, frame_done_d, overflow_d, short_d;
  logic [PIX_W-1:0]   wr_data_d;
  logic               v_rise, de_rise, de_fall, pix_ok;
  logic               unused_h_sync;

  assign v_rise  = v_sync_r & ~v_sync_q;
  assign de_rise = de_r & ~de_q;
  assign de_fall = ~de_r & de_q;
  assign unused_h_sync = h_sync_r ^ h_sync_q;

  // Line number of the pixel now in the input stage (counter lags a line start by one cycle)
  assign line_cur      = de_rise ? line_cnt + LINE_W'(1) : line_cnt;
  assign pix_ok        = de_r && (line_cur > LINE_W'(SKIP_LINES)) && (pix_cnt < PCNT_W'(LINE_PIXELS));
  assign pix_cnt_inc   = (pix_cnt == '1) ? pix_cnt : pix_cnt + PCNT_W'(1);
  assign frame_cnt_inc = (frame_cnt_out == '1) ? frame_cnt_out : frame_cnt_out + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    target_d     = target;
    frame_cnt_d  = frame_cnt_out;
    line_cnt_d   = line_cnt;
    pix_cnt_d    = pix_cnt;
    wr_en_d      = 1'b0;
    wr_data_d    = '0;
    frame_done_d = 1'b0;
    overflow_d   = overflow_err;
    short_d      = short_frame_err;
    case (state)
      S_IDLE: begin
        if (start && (to_recv_frame_num_in != '0)) begin
          state_d     = S_WAIT_VSYNC;
          target_d    = to_recv_frame_num_in;
          frame_cnt_d = '0;
          overflow_d  = 1'b0;
          short_d     = 1'b0;
        end
      end
      S_WAIT_VSYNC: begin
        if (v_rise) begin
          state_d    = S_CAPTURE;
          line_cnt_d = '0;
          pix_cnt_d  = '0;
        end
      end
      S_CAPTURE: begin
        if (v_rise && (line_cnt < LINE_W'(FRAME_LINES))) begin
          // Early vsync: abandon the partial frame and start over
          short_d    = 1'b1;
          line_cnt_d = '0;
          pix_cnt_d  = '0;
        end else begin
          line_cnt_d = line_cur;
          pix_cnt_d  = de_r ? pix_cnt_inc : '0;
          if (pix_ok) begin
            if (pingpong_ready_in) begin
              wr_en_d   = 1'b1;
              wr_data_d = pix_data_r;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (de_fall && (line_cnt == LINE_W'(FRAME_LINES))) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_inc;
            state_d      = (frame_cnt_inc == target) ? S_DONE : S_WAIT_VSYNC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Input stage, edge history, FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_sync_r        <= 1'b0;
      v_sync_r        <= 1'b0;
      de_r            <= 1'b0;
      pix_data_r      <= '0;
      h_sync_q        <= 1'b0;
      v_sync_q        <= 1'b0;
      de_q            <= 1'b0;
      state           <= S_IDLE;
      target          <= '0;
      line_cnt        <= '0;
      pix_cnt         <= '0;
      pp_wr_en        <= 1'b0;
      pp_wr_data      <= '0;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
      overflow_err    <= 1'b0;
      short_frame_err <= 1'b0;
      frame_cnt_out   <= '0;
    end else begin
      h_sync_r        <= h_sync_in;
      v_sync_r        <= v_sync_in;
      de_r            <= de_in;
      pix_data_r      <= pix_data_in;
      h_sync_q        <= h_sync_r;
      v_sync_q        <= v_sync_r;
      de_q            <= de_r;
      state           <= state_d;
      target          <= target_d;
      line_cnt        <= line_cnt_d;
      pix_cnt         <= pix_cnt_d;
      pp_wr_en        <= wr_en_d;
      pp_wr_data      <= wr_data_d;
      frame_done      <= frame_done_d;
      busy            <= (state != S_IDLE);
      overflow_err    <= overflow_d;
      short_frame_err <= short_d;
      frame_cnt_out   <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_wps_recv.sv
// Directed bench for wps_recv: a frame/line/pixel level model predicts every
// write, frame pulse and status flag, and the DUT is compared to it each cycle.
module tb_wps_recv;

  localparam int LP     = 8;
  localparam int FL     = 6;
  localparam int SK     = 1;
  localparam int DE_CYC = 10;
  localparam int HBLANK = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] to_recv_frame_num_in;
  logic        h_sync_in, v_sync_in, de_in;
  logic [23:0] pix_data_in;
  logic        pingpong_ready_in;
  logic        pp_wr_en;
  logic [23:0] pp_wr_data;
  logic        frame_done, busy, overflow_err, short_frame_err;
  logic [31:0] frame_cnt_out;

  wps_recv #(.LINE_PIXELS(LP), .FRAME_LINES(FL), .SKIP_LINES(SK)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .to_recv_frame_num_in (to_recv_frame_num_in),
    .h_sync_in            (h_sync_in),
    .v_sync_in            (v_sync_in),
    .de_in                (de_in),
    .pix_data_in          (pix_data_in),
    .pingpong_ready_in    (pingpong_ready_in),
    .pp_wr_en             (pp_wr_en),
    .pp_wr_data           (pp_wr_data),
    .frame_done           (frame_done),
    .busy                 (busy),
    .overflow_err         (overflow_err),
    .short_frame_err      (short_frame_err),
    .frame_cnt_out        (frame_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  // Model: expected events keyed by the cycle they become visible
  logic [23:0] exp_wr    [int];
  bit          exp_fd    [int];
  logic [31:0] chg_cnt   [int];
  bit          chg_ovf   [int];
  bit          chg_short [int];
  bit          chg_busy  [int];

  bit          m_active = 1'b0;
  bit          m_cap    = 1'b0;
  bit          m_ovf    = 1'b0;
  bit          m_short  = 1'b0;
  logic [31:0] m_frames = '0;
  logic [31:0] m_target = '0;
  bit          rdy_lag  = 1'b1;
  int          pin_cyc  = -1;

  logic [31:0] l_cnt   = '0;
  bit          l_ovf   = 1'b0;
  bit          l_short = 1'b0;
  bit          l_busy  = 1'b0;
  bit          chk_on  = 1'b0;

  int wr_cnt = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int bf_cyc = 0;
  bit busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input cycle; eligible pixels either become a write two cycles on or an overflow
  task automatic drive(input bit hs, input bit vs, input bit de, input logic [23:0] d,
                       input bit rdy, input bit elig);
    tick();
    h_sync_in         = hs;
    v_sync_in         = vs;
    de_in             = de;
    pix_data_in       = d;
    pingpong_ready_in = rdy_lag;
    rdy_lag           = rdy;
    if (elig) begin
      if (rdy) begin
        exp_wr[cyc + 2] = d;
        if (d == 24'hA5A5A5) pin_cyc = cyc + 2;
      end else if (!m_ovf) begin
        m_ovf = 1'b1;
        chg_ovf[cyc + 2] = 1'b1;
      end
    end
  endtask

  task automatic frame_end();
    exp_fd[cyc + 2] = 1'b1;
    if (m_frames != 32'hFFFF_FFFF) m_frames = m_frames + 32'd1;
    chg_cnt[cyc + 2] = m_frames;
    m_cap = 1'b0;
    if (m_frames == m_target) begin
      m_active = 1'b0;
      chg_busy[cyc + 4] = 1'b0;
    end
  endtask

  task automatic send_line(input int l, input int seed, input bit a5,
                           input int r_line, input int r_from, input int r_cnt);
    for (int p = 0; p < DE_CYC; p++) begin
      logic [23:0] d;
      bit rdy;
      d   = (a5 && l == 2 && p == 0) ? 24'hA5A5A5 : 24'((seed << 16) | (l << 8) | p);
      rdy = !(l == r_line && p >= r_from && p < r_from + r_cnt);
      drive(1'b0, 1'b0, 1'b1, d, rdy, m_cap && (l > SK) && (p < LP));
    end
    for (int b = 0; b < HBLANK; b++) begin
      drive(b == 1, 1'b0, 1'b0, 24'd0, 1'b1, 1'b0);
      if (b == 0 && m_cap && l == FL) frame_end();
    end
  endtask

  task automatic send_frame(input int nl, input int seed, input bit a5,
                            input int r_line, input int r_from, input int r_cnt);
    for (int l = 1; l <= nl; l++) send_line(l, seed, a5, r_line, r_from, r_cnt);
  endtask

  task automatic vsync();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i < 2, 1'b0, 24'd0, 1'b1, 1'b0);
      if (i == 0 && m_active) begin
        if (m_cap && !m_short) begin
          m_short = 1'b1;
          chg_short[cyc + 2] = 1'b1;
        end
        m_cap = 1'b1;
      end
    end
  endtask

  task automatic do_start(input logic [31:0] n);
    tick();
    start = 1'b1;
    to_recv_frame_num_in = n;
    if (!m_active && n != 32'd0) begin
      m_active = 1'b1;
      m_target = n;
      m_frames = '0;
      m_ovf    = 1'b0;
      m_short  = 1'b0;
      chg_cnt[cyc + 1]   = '0;
      chg_ovf[cyc + 1]   = 1'b0;
      chg_short[cyc + 1] = 1'b0;
      chg_busy[cyc + 2]  = 1'b1;
    end
    tick();
    start = 1'b0;
  endtask

  // Mid-line reset: everything in flight is lost and all outputs clear on the next edge
  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    for (int i = cyc + 1; i <= cyc + 4; i++) begin
      if (exp_wr.exists(i))    exp_wr.delete(i);
      if (exp_fd.exists(i))    exp_fd.delete(i);
      if (chg_cnt.exists(i))   chg_cnt.delete(i);
      if (chg_ovf.exists(i))   chg_ovf.delete(i);
      if (chg_short.exists(i)) chg_short.delete(i);
      if (chg_busy.exists(i))  chg_busy.delete(i);
    end
    chg_cnt[cyc + 1]   = '0;
    chg_ovf[cyc + 1]   = 1'b0;
    chg_short[cyc + 1] = 1'b0;
    chg_busy[cyc + 1]  = 1'b0;
    m_active = 1'b0;
    m_cap    = 1'b0;
    m_ovf    = 1'b0;
    m_short  = 1'b0;
    m_frames = '0;
    tick();
    chk("rst_wr_en", 32'(pp_wr_en), 32'd0);
    chk("rst_wr_data", 32'(pp_wr_data), 32'd0);
    chk("rst_frame_cnt", frame_cnt_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n       = 1'b1;
    de_in       = 1'b0;
    pix_data_in = '0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      bit          e_en;
      logic [23:0] e_d;
      if (chg_cnt.exists(cyc))   l_cnt   = chg_cnt[cyc];
      if (chg_ovf.exists(cyc))   l_ovf   = chg_ovf[cyc];
      if (chg_short.exists(cyc)) l_short = chg_short[cyc];
      if (chg_busy.exists(cyc))  l_busy  = chg_busy[cyc];
      e_en = exp_wr.exists(cyc);
      e_d  = e_en ? exp_wr[cyc] : 24'd0;
      chk("pp_wr_en", 32'(pp_wr_en), 32'(e_en));
      chk("pp_wr_data", 32'(pp_wr_data), 32'(e_d));
      chk("frame_done", 32'(frame_done), 32'(exp_fd.exists(cyc)));
      chk("frame_cnt_out", frame_cnt_out, l_cnt);
      chk("busy", 32'(busy), 32'(l_busy));
      chk("overflow_err", 32'(overflow_err), 32'(l_ovf));
      chk("short_frame_err", 32'(short_frame_err), 32'(l_short));
      if (cyc == pin_cyc) begin
        chk("a5_wr_en", 32'(pp_wr_en), 32'd1);
        chk("a5_wr_data", 32'(pp_wr_data), 32'hA5A5A5);
      end
    end
  end

  always @(negedge clk) begin
    if (pp_wr_en === 1'b1) wr_cnt++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (busy_prev && busy === 1'b0) bf_cyc = cyc;
    busy_prev = (busy === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    int w0;
    int f0;
    rst_n = 1'b0;
    start = 1'b0;
    to_recv_frame_num_in = '0;
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    de_in = 1'b0;
    pix_data_in = '0;
    pingpong_ready_in = 1'b1;
    repeat (3) tick();
    chk("init_wr_en", 32'(pp_wr_en), 32'd0);
    chk("init_frame_done", 32'(frame_done), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_frame_cnt", frame_cnt_out, 32'd0);
    chk("init_errs", 32'({overflow_err, short_frame_err}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_on = 1'b1;

    // Zero frames requested: start is refused
    do_start(32'd0);
    repeat (4) tick();
    chk("frames0_busy", 32'(busy), 32'd0);

    // Two full frames, marker pixel at the head of line 2
    w0 = wr_cnt;
    f0 = fd_cnt;
    do_start(32'd2);
    vsync();
    send_frame(FL, 1, 1'b1, 0, 0, 0);
    vsync();
    send_frame(FL, 2, 1'b0, 0, 0, 0);
    repeat (3) tick();
    chk("two_frames_writes", 32'(wr_cnt - w0), 32'd80);
    chk("two_frames_done_pulses", 32'(fd_cnt - f0), 32'd2);
    chk("two_frames_cnt", frame_cnt_out, 32'd2);
    chk("two_frames_busy", 32'(busy), 32'd0);
    chk("busy_fall_delay", 32'(bf_cyc - fd_cyc), 32'd2);

    // Start ignored while busy, short frame, then 5 dropped pixels on a full frame
    w0 = wr_cnt;
    do_start(32'd2);
    do_start(32'd1);
    vsync();
    send_frame(3, 5, 1'b0, 0, 0, 0);
    vsync();
    send_frame(FL, 6, 1'b0, 3, 2, 5);
    chk("after_short_cnt", frame_cnt_out, 32'd1);
    chk("after_short_busy", 32'(busy), 32'd1);
    chk("short_err_set", 32'(short_frame_err), 32'd1);
    vsync();
    send_frame(FL, 7, 1'b0, 0, 0, 0);
    repeat (3) tick();
    chk("err_run_cnt", frame_cnt_out, 32'd2);
    chk("err_run_busy", 32'(busy), 32'd0);
    chk("ovf_held", 32'(overflow_err), 32'd1);
    chk("err_run_writes", 32'(wr_cnt - w0), 32'd91);

    // New start clears the flags; reset arrives mid-line
    do_start(32'd1);
    chk("start_clears_ovf", 32'(overflow_err), 32'd0);
    chk("start_clears_short", 32'(short_frame_err), 32'd0);
    vsync();
    send_line(1, 8, 1'b0, 0, 0, 0);
    send_line(2, 8, 1'b0, 0, 0, 0);
    for (int p = 0; p < 4; p++) drive(1'b0, 1'b0, 1'b1, 24'((8 << 16) | (3 << 8) | p), 1'b1, m_cap);
    do_reset();
    repeat (6) tick();
    chk("post_rst_cnt", frame_cnt_out, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(frame_done), 32'd0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/wps_recv.md
WPS_RECV -- requirements
Module: wps_recv

Interface
REQ-001 SHALL have parameter LINE_PIXELS, default 80: pixels captured per active line.
REQ-002 SHALL have parameter FRAME_LINES, default 1081: DE lines per frame, including the offset line.
REQ-003 SHALL have parameter SKIP_LINES, default 1: leading DE lines per frame that are discarded (offset lines).
REQ-004 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: begin reception; sampled in IDLE only.
REQ-007 SHALL have port to_recv_frame_num_in, input, 32: number of frames to capture; latched on accepted start.
REQ-008 SHALL have ports h_sync_in, v_sync_in and de_in, input, 1 each: incoming video timing.
REQ-009 SHALL have port pix_data_in, input, 24: incoming pixel, valid while de_in=1.
REQ-010 SHALL have port pingpong_ready_in, input, 1: pingpong buffer can accept a write this cycle.
REQ-011 SHALL have port pp_wr_en, output, 1: pingpong write strobe.
REQ-012 SHALL have port pp_wr_data, output, 24: pingpong write data.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse per completed frame.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have ports overflow_err and short_frame_err, output, 1 each: sticky error flags.
REQ-016 SHALL have port frame_cnt_out, output, 32: frames completed since the last accepted start.

Function
REQ-017 SHALL register h_sync_in, v_sync_in, de_in and pix_data_in through one input stage (_r); all edge detection SHALL use _r against its previous value.
REQ-018 SHALL implement states IDLE, WAIT_VSYNC, CAPTURE and DONE.
REQ-019 IDLE -> WAIT_VSYNC on start=1 with to_recv_frame_num_in!=0; otherwise SHALL stay in IDLE.
REQ-020 On that transition SHALL latch target=to_recv_frame_num_in, clear frame_cnt_out and clear both error flags.
REQ-021 WAIT_VSYNC -> CAPTURE on the v_sync rising edge; this transition SHALL clear line_cnt and pix_cnt.
REQ-022 In CAPTURE, line_cnt (11 bit) SHALL increment on each de rising edge; pix_cnt (12 bit) SHALL count de_r cycles within a line and reset to 0 when de_r=0.
REQ-023 A pixel is eligible when de_r=1, line_cnt>SKIP_LINES and pix_cnt<LINE_PIXELS; pixels beyond LINE_PIXELS and pixels on skipped lines SHALL be dropped.
REQ-024 For an eligible pixel with pingpong_ready_in=1, pp_wr_en=1 and pp_wr_data=pix_data_r SHALL be presented on the next cycle; total latency is 2 clk from pix_data_in.
REQ-025 For an eligible pixel with pingpong_ready_in=0, the pixel SHALL be dropped and overflow_err set; it SHALL hold until the next accepted start or reset.
REQ-026 pp_wr_data SHALL be 0 whenever pp_wr_en=0.
REQ-027 On the de falling edge with line_cnt==FRAME_LINES, SHALL pulse frame_done for 1 cycle and increment frame_cnt_out.
REQ-028 If the incremented count equals target, SHALL go to DONE; otherwise SHALL go to WAIT_VSYNC.
REQ-029 A v_sync rising edge in CAPTURE with line_cnt<FRAME_LINES SHALL set short_frame_err, discard the partial frame (no frame_done, no count) and restart CAPTURE with counters cleared in the same cycle.
REQ-030 DONE -> IDLE after 1 cycle.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 h_sync SHALL be tracked but SHALL NOT alter capture.
REQ-033 frame_cnt_out SHALL saturate at 0xFFFFFFFF.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force state IDLE and set pp_wr_en, pp_wr_data, frame_done, busy, overflow_err, short_frame_err, frame_cnt_out, line_cnt, pix_cnt, target and the input stage all to 0.
REQ-035 Reset mid-frame SHALL abort the frame: no frame_done pulse, and no pp_wr_en in the cycle after reset.

Verification
REQ-036 start, frames=2, 2 full frames of 1081 lines x 82 DE cycles, ready=1 -> 2x1080x80 writes, line 1 writes nothing, 2 frame_done pulses, frame_cnt_out=2, busy falls 2 cycles after the 2nd frame_done.
REQ-037 Pixel value 0xA5A5A5 as the first pixel on line 2 -> pp_wr_en=1 with pp_wr_data=0xA5A5A5 exactly 2 cycles later.
REQ-038 ready=0 for 5 eligible pixels -> exactly 5 writes missing, overflow_err=1 and held until the next start.
REQ-039 v_sync rising after line 500 -> short_frame_err=1, no frame_done, next full frame counted as frame 1.
REQ-040 start with frames=0 -> stays IDLE, busy=0; start while busy -> target unchanged.
REQ-041 rst_n low mid-line -> all outputs 0 in the next cycle, state IDLE, frame_cnt_out=0.
